// File: rtl/mouse_pos_tracker.sv
// Purpose : assembles 3-byte PS/2 mouse packets into a clamped absolute cursor position and button state.
// Latency : internal position 1 cycle after the third byte; outputs follow at the next vblnk rising edge.
// Backpr. : none; every rx_valid strobe is consumed, and bytes failing sync in B0 are dropped with pkt_err.
//
// Ports   : clk, rst_n (async, active-low); rx_data/rx_valid byte stream from the PS/2 receiver;
//           vblnk from the timing generator; xpos/ypos/left/right frame-stable cursor state;
//           pkt_err one-cycle pulse on a dropped byte or a timed-out packet.
// Option  : define MOUSE_PKT_TIMEOUT_EN to abandon a packet whose inter-byte gap reaches TIMEOUT_CYCLES.
module mouse_pos_tracker #(
    parameter int HOR_PIXELS     = 800,
    parameter int VER_PIXELS     = 600,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        vblnk,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        left,
    output logic        right,
    output logic        pkt_err
);

    localparam logic [11:0]        X_RST = 12'(HOR_PIXELS / 2);
    localparam logic [11:0]        Y_RST = 12'(VER_PIXELS / 2);
    localparam logic signed [13:0] X_MAX = 14'(HOR_PIXELS - 1);
    localparam logic signed [13:0] Y_MAX = 14'(VER_PIXELS - 1);

    typedef enum logic [1:0] {B0, B1, B2} state_t;

    state_t      state;
    logic        flag_l, flag_r, flag_sx, flag_sy, flag_ox, flag_oy;
    logic [7:0]  x_byte;
    logic [11:0] pos_x, pos_y;
    logic        btn_l, btn_r;
    logic        vblnk_q;

    logic [8:0]         dx, dy;
    logic signed [13:0] sum_x, dif_y;
    logic [11:0]        new_x, new_y;
    logic               tmo_hit;

    // Next position, evaluated for the B2 byte currently on rx_data.
    // A flagged overflow zeroes only that axis.
    always_comb begin
        dx    = flag_ox ? 9'd0 : {flag_sx, x_byte};
        dy    = flag_oy ? 9'd0 : {flag_sy, rx_data};
        sum_x = $signed({2'b00, pos_x}) + $signed({{5{dx[8]}}, dx});
        // PS/2 Y grows upward, screen Y grows downward.
        dif_y = $signed({2'b00, pos_y}) - $signed({{5{dy[8]}}, dy});

        if (sum_x < 14'sd0)      new_x = 12'd0;
        else if (sum_x > X_MAX)  new_x = X_MAX[11:0];
        else                     new_x = sum_x[11:0];

        if (dif_y < 14'sd0)      new_y = 12'd0;
        else if (dif_y > Y_MAX)  new_y = Y_MAX[11:0];
        else                     new_y = dif_y[11:0];
    end

`ifdef MOUSE_PKT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;

    // Fires on the idle cycle that brings the inter-byte gap to TIMEOUT_CYCLES.
    assign tmo_hit = (state != B0) && !rx_valid && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          tmo_cnt <= '0;
        else if (state == B0 || rx_valid || tmo_hit) tmo_cnt <= '0;
        else                                 tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= B0;
            flag_l  <= 1'b0;
            flag_r  <= 1'b0;
            flag_sx <= 1'b0;
            flag_sy <= 1'b0;
            flag_ox <= 1'b0;
            flag_oy <= 1'b0;
            x_byte  <= 8'd0;
            pos_x   <= X_RST;
            pos_y   <= Y_RST;
            btn_l   <= 1'b0;
            btn_r   <= 1'b0;
            pkt_err <= 1'b0;
        end else begin
            pkt_err <= 1'b0;
            if (tmo_hit) begin
                state   <= B0;
                pkt_err <= 1'b1;
            end else if (rx_valid) begin
                case (state)
                    B0: begin
                        if (rx_data[3]) begin
                            flag_l  <= rx_data[0];
                            flag_r  <= rx_data[1];
                            flag_sx <= rx_data[4];
                            flag_sy <= rx_data[5];
                            flag_ox <= rx_data[6];
                            flag_oy <= rx_data[7];
                            state   <= B1;
                        end else begin
                            pkt_err <= 1'b1;
                        end
                    end
                    B1: begin
                        x_byte <= rx_data;
                        state  <= B2;
                    end
                    B2: begin
                        pos_x <= new_x;
                        pos_y <= new_y;
                        btn_l <= flag_l;
                        btn_r <= flag_r;
                        state <= B0;
                    end
                    default: state <= B0;
                endcase
            end
        end
    end

    // Shadow copy at vblnk rising edge. A commit in the same cycle is not yet
    // visible here, so it shows one frame later. vblnk_q resets high so a
    // vblnk already high at reset release is not taken as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_q <= 1'b1;
            xpos    <= X_RST;
            ypos    <= Y_RST;
            left    <= 1'b0;
            right   <= 1'b0;
        end else begin
            vblnk_q <= vblnk;
            if (vblnk && !vblnk_q) begin
                xpos  <= pos_x;
                ypos  <= pos_y;
                left  <= btn_l;
                right <= btn_r;
            end
        end
    end

endmodule

// File: tb/tb_mouse_pos_tracker.sv
module tb_mouse_pos_tracker;

    localparam int HP = 800;
    localparam int VP = 600;
    localparam int TO = 100;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        l;
        logic        r;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        vblnk = 1'b1;
    logic [11:0] xpos, ypos;
    logic        left, right, pkt_err;

    mouse_pos_tracker #(.HOR_PIXELS(HP), .VER_PIXELS(VP), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .vblnk(vblnk),
        .xpos(xpos), .ypos(ypos), .left(left), .right(right), .pkt_err(pkt_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: cursor state and the bytes of the packet in progress.
    int   mx = HP / 2, my = VP / 2;
    bit   ml = 0, mr = 0;
    logic [7:0] pend[$];
    int   idle = 0;
    int   exp_err = 0;
    int   got_err = 0;
    bit   drv_prev_vb = 1'b1;
    out_t exp_q[$];

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic void apply_pkt(input logic [7:0] f, input logic [7:0] xb, input logic [7:0] yb);
        int dx, dy;
        dx = f[6] ? 0 : (f[4] ? int'(xb) - 256 : int'(xb));
        dy = f[7] ? 0 : (f[5] ? int'(yb) - 256 : int'(yb));
        mx = clampi(mx + dx, HP - 1);
        my = clampi(my - dy, VP - 1);
        ml = f[0];
        mr = f[1];
    endfunction

    function automatic void model_reset();
        mx = HP / 2; my = VP / 2; ml = 0; mr = 0;
        pend.delete();
        idle = 0;
        drv_prev_vb = 1'b1;
    endfunction

    // One cycle of stimulus. An output snapshot is queued for a vblnk rising
    // edge before any packet completing in the same cycle is applied.
    task automatic drive(input logic v, input logic [7:0] d, input logic vb);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        vblnk    = vb;
        if (vb && !drv_prev_vb) exp_q.push_back(out_t'{12'(mx), 12'(my), ml, mr});
        drv_prev_vb = vb;
        if (v) begin
            idle = 0;
            if (pend.size() == 0 && !d[3]) begin
                exp_err++;
            end else begin
                pend.push_back(d);
                if (pend.size() == 3) begin
                    apply_pkt(pend[0], pend[1], pend[2]);
                    pend.delete();
                end
            end
        end else if (pend.size() != 0) begin
            idle++;
`ifdef MOUSE_PKT_TIMEOUT_EN
            if (idle == TO) begin
                pend.delete();
                exp_err++;
                idle = 0;
            end
`endif
        end
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        drive(1'b1, a, 1'b0);
        drive(1'b1, b, 1'b0);
        drive(1'b1, c, 1'b0);
    endtask

    task automatic frame();
        drive(1'b0, 8'd0, 1'b1);
        drive(1'b0, 8'd0, 1'b0);
        drive(1'b0, 8'd0, 1'b0);
    endtask

    task automatic do_reset(input logic vb);
        @(negedge clk);
        rst_n = 1'b0; rx_valid = 1'b0; vblnk = vb;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_out(input string name, input int x, input int y, input bit l, input bit r);
        n_cmp++;
        if (xpos !== 12'(x) || ypos !== 12'(y) || left !== l || right !== r) begin
            n_bad++;
            $display("FAIL %s: got x=%0d y=%0d l=%0b r=%0b, want x=%0d y=%0d l=%0b r=%0b",
                     name, xpos, ypos, left, right, x, y, l, r);
        end
    endtask

    // Monitor: tracks vblnk edges as the DUT samples them, pops the expected
    // snapshot after each edge, and otherwise checks that outputs hold.
    logic mon_prev, mon_edge;
    out_t mon_last;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_prev <= 1'b1;
            mon_edge <= 1'b0;
        end else begin
            mon_edge <= vblnk && !mon_prev;
            mon_prev <= vblnk;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_last = out_t'{12'(HP / 2), 12'(VP / 2), 1'b0, 1'b0};
        end else begin
            if (pkt_err) got_err++;
            n_cmp++;
            if (mon_edge) begin
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL edge_no_expect: vblnk edge with empty scoreboard");
                end else begin
                    mon_last = exp_q.pop_front();
                end
            end
            if (xpos !== mon_last.x || ypos !== mon_last.y || left !== mon_last.l || right !== mon_last.r) begin
                n_bad++;
                $display("FAIL %s: got x=%0d y=%0d l=%0b r=%0b, want x=%0d y=%0d l=%0b r=%0b",
                         mon_edge ? "frame_update" : "frame_hold", xpos, ypos, left, right,
                         mon_last.x, mon_last.y, mon_last.l, mon_last.r);
            end
        end
    end

    initial begin
        int cyc;
        logic [7:0] b;
        logic v;

        // Reset with vblnk already high: no false edge on release.
        do_reset(1'b1);
        drive(1'b0, 8'd0, 1'b1);
        drive(1'b0, 8'd0, 1'b1);
        check_out("reset_out", 400, 300, 0, 0);
        n_cmp++;
        if (pkt_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", pkt_err); end
        drive(1'b0, 8'd0, 1'b0);
        frame();
        check_out("first_frame", 400, 300, 0, 0);

        // Basic move.
        send3(8'h09, 8'h0A, 8'h05);
        check_out("hold_before_vblnk", 400, 300, 0, 0);
        frame();
        check_out("basic_move", 410, 295, 1, 0);

        // Resync after a byte without the sync bit.
        drive(1'b1, 8'h05, 1'b0);
        drive(1'b0, 8'd0, 1'b0);
        n_cmp++;
        if (pkt_err !== 1'b1) begin n_bad++; $display("FAIL resync_err: got %0b want 1", pkt_err); end
        drive(1'b0, 8'd0, 1'b0);
        n_cmp++;
        if (pkt_err !== 1'b0) begin n_bad++; $display("FAIL resync_err_len: got %0b want 0", pkt_err); end
        send3(8'h08, 8'h01, 8'h00);
        frame();
        check_out("resync_move", 411, 295, 0, 0);

        // X overflow: X frozen, Y still moves.
        send3(8'h48, 8'hFF, 8'h02);
        frame();
        check_out("overflow_x", 411, 293, 0, 0);

        // Commit coincident with the vblnk edge: old value this frame.
        drive(1'b1, 8'h0A, 1'b0);
        drive(1'b1, 8'h03, 1'b0);
        drive(1'b1, 8'h00, 1'b1);
        drive(1'b0, 8'd0, 1'b0);
        drive(1'b0, 8'd0, 1'b0);
        check_out("same_cycle_old", 411, 293, 0, 0);
        frame();
        check_out("same_cycle_new", 414, 293, 0, 1);

        // Reset mid-packet discards the partial packet.
        drive(1'b1, 8'h08, 1'b0);
        drive(1'b1, 8'h05, 1'b0);
        do_reset(1'b0);
        drive(1'b0, 8'd0, 1'b0);
        check_out("midpkt_reset", 400, 300, 0, 0);
        send3(8'h08, 8'h01, 8'h00);
        frame();
        check_out("after_reset_move", 401, 300, 0, 0);

        // Negative deltas with clamping at the left edge.
        do_reset(1'b0);
        drive(1'b0, 8'd0, 1'b0);
        send3(8'h38, 8'h00, 8'h80);
        send3(8'h38, 8'h00, 8'h80);
        frame();
        check_out("clamp_neg", 0, 556, 0, 0);

`ifdef MOUSE_PKT_TIMEOUT_EN
        drive(1'b1, 8'h08, 1'b0);
        drive(1'b1, 8'h05, 1'b0);
        repeat (TO) drive(1'b0, 8'd0, 1'b0);
        drive(1'b0, 8'd0, 1'b0);
        n_cmp++;
        if (pkt_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %0b want 1", pkt_err); end
        send3(8'h08, 8'h01, 8'h00);
        frame();
        check_out("timeout_move", 1, 556, 0, 0);
`endif

        // Randomized traffic with periodic frames.
        for (cyc = 0; cyc < 4000; cyc++) begin
            v = ($urandom_range(0, 1) == 1);
            b = 8'($urandom);
            if (pend.size() == 0) begin
                if ($urandom_range(0, 9) == 0) b[3] = 1'b0;
                else begin
                    b[3] = 1'b1;
                    if ($urandom_range(0, 7) != 0) b[7:6] = 2'b00;
                end
            end
            drive(v, b, (cyc % 37) < 3);
        end

        // Drain outstanding frames.
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) drive(1'b0, 8'd0, (i % 20) == 5);
        repeat (4) drive(1'b0, 8'd0, 1'b0);
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL drain: %0d frames left, want 0", exp_q.size()); end
        n_cmp++;
        if (got_err != exp_err) begin n_bad++; $display("FAIL err_count: got %0d want %0d", got_err, exp_err); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
